// File: rtl/neuron_pkg.sv
// Shared types, constants and saturating arithmetic for the LIF neuron.
package neuron_pkg;

    localparam int unsigned DEF_N_SYN         = 8;
    localparam int unsigned DEF_ADDR_W        = 12;
    localparam int unsigned DEF_W_W           = 8;
    localparam int unsigned DEF_PW            = 16;
    localparam int unsigned DEF_REFRACT_STEPS = 2;

    localparam logic MODE_IF  = 1'b0;
    localparam logic MODE_LIF = 1'b1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DECAY = 2'd1,
        ST_INTEG = 2'd2,
        ST_FIRE  = 2'd3
    } state_t;

    // Signed add clamped to the range of a w-bit two's complement value (w <= 31).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned        w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -hi - 33'sd1;
        if (sum > hi) begin
            return 32'(hi);
        end
        if (sum < lo) begin
            return 32'(lo);
        end
        return 32'(sum);
    endfunction

endpackage

// File: rtl/neuron_lif_p_if.sv
// Valid/ready spike-event channel from the NoC router port into the neuron.
interface neuron_lif_p_if
    import neuron_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic              spike_in_valid;
    logic              spike_in_ready;
    logic [ADDR_W-1:0] spike_in_src;

    modport master (output spike_in_valid, output spike_in_src, input  spike_in_ready);
    modport slave  (input  spike_in_valid, input  spike_in_src, output spike_in_ready);

endinterface

// File: rtl/synapse_cam.sv
// Synapse table: source-address/weight entries with parallel lowest-index match.
module synapse_cam
    import neuron_pkg::*;
#(
    parameter int unsigned N_SYN  = DEF_N_SYN,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned W_W    = DEF_W_W,
    parameter int unsigned IDX_W  = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     i_cfg_we,
    input  logic [IDX_W-1:0]         i_cfg_idx,
    input  logic [ADDR_W-1:0]        i_cfg_src_addr,
    input  logic signed [W_W-1:0]    i_cfg_weight,
    input  logic [ADDR_W-1:0]        i_lookup_src,
    output logic                     o_hit,
    output logic signed [W_W-1:0]    o_weight
);

    logic [N_SYN-1:0]         r_valid;
    logic [ADDR_W-1:0]        r_src    [N_SYN];
    logic signed [W_W-1:0]    r_weight [N_SYN];
    logic                     w_idx_ok;

    assign w_idx_ok = (32'(i_cfg_idx) < N_SYN);

    // Valid bits: cleared by reset, set by any configuration write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= '0;
        end else if (i_cfg_we && w_idx_ok) begin
            r_valid[i_cfg_idx] <= 1'b1;
        end
    end

    // Entry contents; only meaningful once the matching valid bit is set.
    always_ff @(posedge CLK) begin
        if (i_cfg_we && w_idx_ok) begin
            r_src[i_cfg_idx]    <= i_cfg_src_addr;
            r_weight[i_cfg_idx] <= i_cfg_weight;
        end
    end

    // Parallel compare; scanning downwards lets the lowest matching index win.
    always_comb begin
        o_hit    = 1'b0;
        o_weight = '0;
        for (int i = int'(N_SYN) - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_src[i] == i_lookup_src)) begin
                o_hit    = 1'b1;
                o_weight = r_weight[i];
            end
        end
    end

endmodule

// File: rtl/neuron_lif_p.sv
// Parametrised IF/LIF neuron with spike-event accumulation and a timestep FSM.
// Optional refractory period enabled by defining NEURON_REFRACTORY_EN.
module neuron_lif_p
    import neuron_pkg::*;
#(
    parameter  int unsigned N_SYN         = DEF_N_SYN,
    parameter  int unsigned ADDR_W        = DEF_ADDR_W,
    parameter  int unsigned W_W           = DEF_W_W,
    parameter  int unsigned PW            = DEF_PW,
    parameter  int unsigned REFRACT_STEPS = DEF_REFRACT_STEPS,
    localparam int unsigned IDX_W         = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_W-1:0]     neuron_address,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [ADDR_W-1:0]     cfg_src_addr,
    input  logic signed [W_W-1:0] cfg_weight,
    input  logic signed [PW-1:0]  v_threshold,
    input  logic signed [PW-1:0]  v_reset,
    input  logic [3:0]            decay_rate,
    input  logic                  mode,
    neuron_lif_p_if.slave         spike_in,
    input  logic                  timestep,
    output logic                  spike,
    output logic signed [PW-1:0]  membrane_potential,
    output logic                  busy
);

    localparam int unsigned REF_W = (REFRACT_STEPS > 1) ? $clog2(REFRACT_STEPS + 1) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [PW-1:0]  r_v;
    logic signed [PW-1:0]  w_v_nxt;
    logic signed [PW-1:0]  r_acc;
    logic signed [PW-1:0]  w_acc_nxt;
    logic                  r_spike;
    logic                  w_spike_nxt;
    logic                  w_fire;
    logic                  w_accept;
    logic                  w_hit;
    logic signed [W_W-1:0] w_weight;
    logic signed [PW-1:0]  w_acc_sum;
    logic signed [PW-1:0]  w_v_sum;
    logic                  w_refr_active;
    logic                  w_unused;

    // Own address is status-only and carries no behaviour inside the neuron.
    assign w_unused = ^neuron_address;

    synapse_cam #(
        .N_SYN  (N_SYN),
        .ADDR_W (ADDR_W),
        .W_W    (W_W),
        .IDX_W  (IDX_W)
    ) u_cam (
        .CLK            (CLK),
        .RESET          (RESET),
        .i_cfg_we       (cfg_we),
        .i_cfg_idx      (cfg_idx),
        .i_cfg_src_addr (cfg_src_addr),
        .i_cfg_weight   (cfg_weight),
        .i_lookup_src   (spike_in.spike_in_src),
        .o_hit          (w_hit),
        .o_weight       (w_weight)
    );

    assign spike_in.spike_in_ready = (r_state == ST_ACCUM) && !timestep;
    assign w_accept  = spike_in.spike_in_valid && spike_in.spike_in_ready;
    assign w_acc_sum = PW'(sat_add(32'(r_acc), 32'(w_weight), PW));
    assign w_v_sum   = PW'(sat_add(32'(r_v), 32'(r_acc), PW));

`ifdef NEURON_REFRACTORY_EN
    logic [REF_W-1:0] r_refr;

    // Refractory counter: loaded by a spike, counts down once per timestep.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_refr <= '0;
        end else if (r_state == ST_FIRE) begin
            if (w_fire) begin
                r_refr <= REF_W'(REFRACT_STEPS);
            end else if (r_refr != '0) begin
                r_refr <= r_refr - REF_W'(1);
            end
        end
    end

    assign w_refr_active = (r_refr != '0);
`else
    logic [REF_W-1:0] w_refr;

    assign w_refr        = '0;
    assign w_refr_active = (w_refr != '0);
`endif

    // Next-state and datapath updates for the timestep sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_v_nxt     = r_v;
        w_acc_nxt   = r_acc;
        w_spike_nxt = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && w_hit && !w_refr_active) begin
                    w_acc_nxt = w_acc_sum;
                end
                if (timestep) begin
                    w_state_nxt = ST_DECAY;
                end
            end
            ST_DECAY: begin
                if ((mode == MODE_LIF) && (decay_rate != 4'd0)) begin
                    w_v_nxt = r_v - (r_v >>> decay_rate);
                end
                w_state_nxt = ST_INTEG;
            end
            ST_INTEG: begin
                if (!w_refr_active) begin
                    w_v_nxt = w_v_sum;
                end
                w_acc_nxt   = '0;
                w_state_nxt = ST_FIRE;
            end
            ST_FIRE: begin
                if (!w_refr_active && (r_v >= v_threshold)) begin
                    w_fire      = 1'b1;
                    w_spike_nxt = 1'b1;
                    w_v_nxt     = v_reset;
                end
                w_state_nxt = ST_ACCUM;
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    // State, potential, accumulator and spike registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_ACCUM;
            r_v     <= '0;
            r_acc   <= '0;
            r_spike <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_v     <= w_v_nxt;
            r_acc   <= w_acc_nxt;
            r_spike <= w_spike_nxt;
        end
    end

    assign spike              = r_spike;
    assign membrane_potential = r_v;
    assign busy               = (r_state != ST_ACCUM);

endmodule

// File: tb/tb_neuron_lif_p.sv
// Bench for neuron_lif_p: directed scenarios plus randomized timesteps against
// an arithmetic reference model of the neuron.
module tb_neuron_lif_p;

    localparam int N_SYN  = 8;
    localparam int ADDR_W = 12;
    localparam int W_W    = 8;
    localparam int PW     = 16;
`ifdef NEURON_REFRACTORY_EN
    localparam int REFR   = 2;
`else
    localparam int REFR   = 0;
`endif

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic [ADDR_W-1:0]     neuron_address;
    logic                  cfg_we;
    logic [2:0]            cfg_idx;
    logic [ADDR_W-1:0]     cfg_src_addr;
    logic signed [W_W-1:0] cfg_weight;
    logic signed [PW-1:0]  v_threshold;
    logic signed [PW-1:0]  v_reset;
    logic [3:0]            decay_rate;
    logic                  mode;
    logic                  timestep;
    logic                  spike;
    logic signed [PW-1:0]  membrane_potential;
    logic                  busy;

    neuron_lif_p_if #(.ADDR_W(ADDR_W)) u_if ();

    neuron_lif_p #(
        .N_SYN(N_SYN), .ADDR_W(ADDR_W), .W_W(W_W), .PW(PW), .REFRACT_STEPS(2)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .neuron_address     (neuron_address),
        .cfg_we             (cfg_we),
        .cfg_idx            (cfg_idx),
        .cfg_src_addr       (cfg_src_addr),
        .cfg_weight         (cfg_weight),
        .v_threshold        (v_threshold),
        .v_reset            (v_reset),
        .decay_rate         (decay_rate),
        .mode               (mode),
        .spike_in           (u_if),
        .timestep           (timestep),
        .spike              (spike),
        .membrane_potential (membrane_potential),
        .busy               (busy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit m_val [N_SYN];
    int m_src [N_SYN];
    int m_w   [N_SYN];
    int m_v, m_acc, m_refr;
    int m_thr, m_vres, m_dec;
    bit m_mode;

    function automatic int clamp(input int x);
        int hi;
        int lo;
        hi = (1 <<< (PW - 1)) - 1;
        lo = -(1 <<< (PW - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_SYN; i++) m_val[i] = 1'b0;
        m_v = 0; m_acc = 0; m_refr = 0;
    endtask

    task automatic set_params(input bit md, input int dec, input int thr, input int vres);
        m_mode = md; m_dec = dec; m_thr = thr; m_vres = vres;
        mode        = md;
        decay_rate  = 4'(dec);
        v_threshold = PW'(thr);
        v_reset     = PW'(vres);
    endtask

    task automatic model_event(input int src);
        for (int i = 0; i < N_SYN; i++) begin
            if (m_val[i] && m_src[i] == src) begin
                if (m_refr == 0) m_acc = clamp(m_acc + m_w[i]);
                break;
            end
        end
    endtask

    task automatic cfg_write(input int idx, input int src, input int w);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_src_addr = ADDR_W'(src); cfg_weight = W_W'(w);
        step();
        cfg_we = 1'b0;
        m_val[idx] = 1'b1; m_src[idx] = src; m_w[idx] = w;
    endtask

    task automatic send_event(input int src);
        int waited;
        waited = 0;
        while (u_if.spike_in_ready !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        check("ready_before_event", 32'(u_if.spike_in_ready), 1);
        u_if.spike_in_valid = 1'b1;
        u_if.spike_in_src   = ADDR_W'(src);
        model_event(src);
        step();
        u_if.spike_in_valid = 1'b0;
    endtask

    task automatic run_timestep(input string tag);
        int v_dec, v_int, v_fin, fire;
        v_dec = (m_mode && m_dec != 0) ? (m_v - (m_v >>> m_dec)) : m_v;
        v_int = (m_refr != 0) ? v_dec : clamp(v_dec + m_acc);
        fire  = 0;
        v_fin = v_int;
        if (m_refr != 0) begin
            m_refr--;
        end else if (v_int >= m_thr) begin
            fire  = 1;
            v_fin = m_vres;
            m_refr = REFR;
        end
        timestep = 1'b1;
        step();
        timestep = 1'b0;
        check({tag, "_busy_t1"}, 32'(busy), 1);
        check({tag, "_spike_t1"}, 32'(spike), 0);
        step();
        check({tag, "_busy_t2"}, 32'(busy), 1);
        check({tag, "_v_decay"}, 32'(membrane_potential), v_dec);
        step();
        check({tag, "_busy_t3"}, 32'(busy), 1);
        check({tag, "_v_integ"}, 32'(membrane_potential), v_int);
        check({tag, "_spike_t3"}, 32'(spike), 0);
        step();
        check({tag, "_busy_t4"}, 32'(busy), 0);
        check({tag, "_spike_t4"}, 32'(spike), fire);
        check({tag, "_v_final"}, 32'(membrane_potential), v_fin);
        m_v   = v_fin;
        m_acc = 0;
        step();
        check({tag, "_spike_t5"}, 32'(spike), 0);
    endtask

    initial begin
        RESET = 1'b1; neuron_address = 12'h123; cfg_we = 1'b0; cfg_idx = '0;
        cfg_src_addr = '0; cfg_weight = '0; timestep = 1'b0;
        u_if.spike_in_valid = 1'b0; u_if.spike_in_src = '0;
        set_params(1'b0, 0, 100, 0);
        model_reset();
        step(); step();
        RESET = 1'b0;
        step();

        // Reset state
        check("rst_v", 32'(membrane_potential), 0);
        check("rst_spike", 32'(spike), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(u_if.spike_in_ready), 1);

        // Empty timestep
        run_timestep("empty");

        // IF: two events of 60 cross threshold 100
        cfg_write(0, 12'h005, 60);
        send_event(12'h005);
        send_event(12'h005);
        run_timestep("if_fire");

        // LIF: charge to 80 then decay by half
        set_params(1'b1, 1, 200, 0);
        cfg_write(1, 12'h007, 80);
        send_event(12'h007);
        run_timestep("lif_charge");
        run_timestep("lif_decay");

        // Unconfigured source: consumed, no effect
        set_params(1'b0, 0, 200, 0);
        send_event(12'h00A);
        run_timestep("unconf");

        // Positive saturation of the accumulator
        set_params(1'b0, 0, 32767, 0);
        cfg_write(2, 12'h0FF, 127);
        for (int i = 0; i < 300; i++) send_event(12'h0FF);
        run_timestep("sat");

        // Same-cycle write and lookup on entry 0 uses the old weight; lowest index wins
        set_params(1'b0, 0, 1000, 0);
        cfg_write(3, 12'h005, 1);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_src_addr = 12'h005; cfg_weight = 8'sd10;
        u_if.spike_in_valid = 1'b1; u_if.spike_in_src = 12'h005;
        check("samecyc_ready", 32'(u_if.spike_in_ready), 1);
        model_event(12'h005);
        step();
        cfg_we = 1'b0; u_if.spike_in_valid = 1'b0;
        m_w[0] = 10;
        send_event(12'h005);
        run_timestep("samecyc");

        // Reset while in DECAY with a pending accumulator
        cfg_write(4, 12'h033, 50);
        send_event(12'h033);
        timestep = 1'b1;
        step();
        timestep = 1'b0;
        check("mid_busy", 32'(busy), 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        model_reset();
        check("mid_v", 32'(membrane_potential), 0);
        check("mid_busy_after", 32'(busy), 0);
        check("mid_spike", 32'(spike), 0);
        step();
        check("mid_spike2", 32'(spike), 0);
        set_params(1'b0, 0, 1, 0);
        run_timestep("mid_acc_clear");

`ifdef NEURON_REFRACTORY_EN
        // Refractory: two timesteps after a spike ignore events, the third fires
        set_params(1'b0, 0, 100, 0);
        cfg_write(0, 12'h009, 120);
        send_event(12'h009);
        run_timestep("refr_fire");
        for (int k = 0; k < 3; k++) begin
            send_event(12'h009);
            run_timestep($sformatf("refr_ts%0d", k));
        end
        check("refr_third_fired", 32'(membrane_potential), 0);
`endif

        // Randomized timesteps against the model
        for (int ts = 0; ts < 40; ts++) begin
            set_params(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 800)) - 200, int'($urandom_range(0, 100)) - 50);
            for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
                cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(1, 6)),
                          int'($urandom_range(0, 255)) - 128);
            end
            for (int e = 0; e < int'($urandom_range(0, 8)); e++) begin
                send_event(int'($urandom_range(0, 7)));
            end
            run_timestep($sformatf("rnd%0d", ts));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
